// File: rtl/io_pwm_bridge.sv
// Memory-mapped six-channel PWM peripheral on the CPU mem-stage IO port.
// Loads return combinationally; duty/period updates are double-buffered and applied at period wrap.
module io_pwm_bridge #(
    parameter int unsigned PRESCALE     = 100,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RESET_PERIOD = 20000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IOinsn,
    input  logic [31:0] memAddr,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic [5:0]  JA
);

    localparam int unsigned PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned N_CH   = 6;
    localparam int unsigned WRAP_W = 16;
    localparam logic [1:0]  RGN_WR = 2'b01;
    localparam logic [1:0]  RGN_RD = 2'b10;

    logic [PS_W-1:0]   ps_q, ps_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_sh_q, period_sh_d;
    logic [CNT_W-1:0]  period_act_q, period_act_d;
    logic [CNT_W-1:0]  duty_sh_q [N_CH];
    logic [CNT_W-1:0]  duty_sh_d [N_CH];
    logic [CNT_W-1:0]  duty_act_q [N_CH];
    logic [CNT_W-1:0]  duty_act_d [N_CH];
    logic [5:0]        enable_q, enable_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic              pending_q, pending_d;
    logic [5:0]        ja_q, ja_d;

    logic [3:0] off;
    logic       wr_en, halted, tick, last, wrap, shadow_wr;
    logic       unused_bits;

    assign off       = memAddr[3:0];
    assign wr_en     = IOinsn && (memAddr[13:12] == RGN_WR);
    assign halted    = (period_act_q == '0);
    assign tick      = !halted && (ps_q == PS_W'(PRESCALE - 1));
    assign last      = (cnt_q == period_act_q - CNT_W'(1));
    assign wrap      = tick && last;
    assign shadow_wr = wr_en && (off <= 4'd6);
    assign JA        = ja_q;

    assign unused_bits = ^{memAddr[31:14], memAddr[11:4], dataIn[31:CNT_W]};

    // Next-state: timebase, register writes, wrap-time shadow transfer, PWM compare
    always_comb begin
        ps_d         = ps_q;
        cnt_d        = cnt_q;
        period_sh_d  = period_sh_q;
        period_act_d = period_act_q;
        duty_sh_d    = duty_sh_q;
        duty_act_d   = duty_act_q;
        enable_d     = enable_q;
        wraps_d      = wraps_q;
        pending_d    = pending_q;
        ja_d         = '0;

        if (halted) begin
            ps_d  = '0;
            cnt_d = '0;
        end else if (tick) begin
            ps_d  = '0;
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end else begin
            ps_d = ps_q + PS_W'(1);
        end

        // Transfer uses pre-write shadow values, so a coincident write lands at the next wrap
        if (wrap || halted) begin
            period_act_d = period_sh_q;
            duty_act_d   = duty_sh_q;
        end

        for (int i = 0; i < N_CH; i++) begin
            if (wr_en && off == 4'(i)) duty_sh_d[i] = dataIn[CNT_W-1:0];
        end
        if (wr_en && off == 4'd6) period_sh_d = dataIn[CNT_W-1:0];
        if (wr_en && off == 4'd7) enable_d = dataIn[5:0];

        if (wr_en && off == 4'd8) wraps_d = '0;
        else if (wrap)            wraps_d = wraps_q + WRAP_W'(1);

        if (shadow_wr) pending_d = 1'b1;
        else if (wrap) pending_d = 1'b0;

        for (int i = 0; i < N_CH; i++) begin
            ja_d[i] = enable_q[i] && !halted && (cnt_q < duty_act_q[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ps_q         <= '0;
            cnt_q        <= '0;
            period_sh_q  <= CNT_W'(RESET_PERIOD);
            period_act_q <= CNT_W'(RESET_PERIOD);
            for (int i = 0; i < N_CH; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
            enable_q     <= '0;
            wraps_q      <= '0;
            pending_q    <= 1'b0;
            ja_q         <= '0;
        end else begin
            ps_q         <= ps_d;
            cnt_q        <= cnt_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            duty_sh_q    <= duty_sh_d;
            duty_act_q   <= duty_act_d;
            enable_q     <= enable_d;
            wraps_q      <= wraps_d;
            pending_q    <= pending_d;
            ja_q         <= ja_d;
        end
    end

    // Load data is combinational so the M/W latch captures it in the same cycle
    always_comb begin
        dataOut = '0;
        if (reset && IOinsn && memAddr[13:12] == RGN_RD) begin
            case (off)
                4'd6:    dataOut = 32'(period_sh_q);
                4'd7:    dataOut = 32'(enable_q);
                4'd8:    dataOut = 32'(wraps_q);
                4'd9:    dataOut = {16'(cnt_q), 15'd0, pending_q};
                default: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (off == 4'(i)) dataOut = 32'(duty_sh_q[i]);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_pwm_bridge.sv
// Directed bench for io_pwm_bridge: one PRESCALE=1 instance for PWM behaviour and wrap counter
// rollover, one PRESCALE=4/RESET_PERIOD=2 instance for prescaled wrap timing and region decode.
module tb_io_pwm_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        io1, io4;
    logic [31:0] addr1, addr4, din1, din4, dout1, dout4;
    logic [5:0]  ja1, ja4;
    logic [15:0] pat;

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;

    always #50 clock = ~clock;

    io_pwm_bridge #(.PRESCALE(1), .CNT_W(16), .RESET_PERIOD(20000)) dut1 (
        .clock(clock), .reset(reset), .IOinsn(io1), .memAddr(addr1),
        .dataIn(din1), .dataOut(dout1), .JA(ja1)
    );

    io_pwm_bridge #(.PRESCALE(4), .CNT_W(16), .RESET_PERIOD(2)) dut4 (
        .clock(clock), .reset(reset), .IOinsn(io4), .memAddr(addr4),
        .dataIn(din4), .dataOut(dout4), .JA(ja4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        edges++;
    endtask

    task automatic skip_to(input int target);
        while (edges < target) tick();
    endtask

    task automatic set_bus(input bit d4, input bit en, input logic [1:0] rg,
                           input logic [3:0] off, input logic [31:0] d);
        if (d4) begin
            io4 = en; addr4 = {18'd0, rg, 8'd0, off}; din4 = d;
        end else begin
            io1 = en; addr1 = {18'd0, rg, 8'd0, off}; din1 = d;
        end
    endtask

    task automatic idle();
        set_bus(1'b0, 1'b0, 2'b00, 4'd0, 32'd0);
        set_bus(1'b1, 1'b0, 2'b00, 4'd0, 32'd0);
    endtask

    task automatic wr(input bit d4, input logic [3:0] off, input logic [31:0] d);
        set_bus(d4, 1'b1, 2'b01, off, d);
        tick();
        idle();
    endtask

    task automatic rd_chk(input string tag, input bit d4, input bit en, input logic [1:0] rg,
                          input logic [3:0] off, input logic [31:0] exp);
        set_bus(d4, en, rg, off, 32'd0);
        #1;
        chk(tag, d4 ? dout4 : dout1, exp);
        idle();
    endtask

    task automatic cap(input int ch, input int n);
        pat = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            pat[i] = ja1[ch];
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();

        // Reset held two edges with writes on the bus; reset must win
        set_bus(1'b0, 1'b1, 2'b01, 4'd6, 32'd5);
        set_bus(1'b1, 1'b1, 2'b01, 4'd7, 32'h3F);
        tick();
        set_bus(1'b0, 1'b1, 2'b01, 4'd0, 32'd9);
        tick();
        rd_chk("rst_dout_zero", 1'b0, 1'b1, 2'b10, 4'd6, 32'd0);
        reset = 1'b1;
        edges = 0;
        #1;
        rd_chk("rst_period", 1'b0, 1'b1, 2'b10, 4'd6, 32'd20000);
        rd_chk("rst_enable", 1'b0, 1'b1, 2'b10, 4'd7, 32'd0);
        rd_chk("rst_duty0", 1'b0, 1'b1, 2'b10, 4'd0, 32'd0);
        rd_chk("rst_status", 1'b0, 1'b1, 2'b10, 4'd9, 32'd0);
        rd_chk("rst_wraps", 1'b0, 1'b1, 2'b10, 4'd8, 32'd0);
        rd_chk("rst4_enable", 1'b1, 1'b1, 2'b10, 4'd7, 32'd0);
        rd_chk("rst4_period", 1'b1, 1'b1, 2'b10, 4'd6, 32'd2);
        chk("rst_ja1", 32'(ja1), 32'd0);
        chk("rst_ja4", 32'(ja4), 32'd0);

        // Program period=10, duty0=3, enable=1 at edges 1..3
        wr(1'b0, 4'd6, 32'd10);
        wr(1'b0, 4'd0, 32'd3);
        wr(1'b0, 4'd7, 32'd1);
        rd_chk("pend_before", 1'b0, 1'b1, 2'b10, 4'd9, 32'h0003_0001);
        rd_chk("shadow_period", 1'b0, 1'b1, 2'b10, 4'd6, 32'd10);

        // Prescaled instance: wrap every 8 edges
        skip_to(7);
        rd_chk("p4_wraps_e7", 1'b1, 1'b1, 2'b10, 4'd8, 32'd0);
        rd_chk("p4_cnt_e7", 1'b1, 1'b1, 2'b10, 4'd9, 32'h0001_0000);
        tick();
        rd_chk("p4_wraps_e8", 1'b1, 1'b1, 2'b10, 4'd8, 32'd1);
        rd_chk("p4_cnt_e8", 1'b1, 1'b1, 2'b10, 4'd9, 32'd0);
        skip_to(16);
        rd_chk("p4_wraps_e16", 1'b1, 1'b1, 2'b10, 4'd8, 32'd2);
        skip_to(23);
        wr(1'b1, 4'd8, 32'd0);
        rd_chk("p4_clr_at_wrap", 1'b1, 1'b1, 2'b10, 4'd8, 32'd0);
        skip_to(31);
        rd_chk("p4_wraps_e31", 1'b1, 1'b1, 2'b10, 4'd8, 32'd0);
        tick();
        rd_chk("p4_wraps_e32", 1'b1, 1'b1, 2'b10, 4'd8, 32'd1);
        rd_chk("rgn11_read", 1'b1, 1'b1, 2'b11, 4'd8, 32'd0);
        rd_chk("rgn00_read", 1'b1, 1'b1, 2'b00, 4'd8, 32'd0);
        rd_chk("noio_read", 1'b1, 1'b0, 2'b10, 4'd8, 32'd0);
        set_bus(1'b1, 1'b1, 2'b11, 4'd6, 32'd5);
        tick();
        idle();
        rd_chk("rgn11_nowrite", 1'b1, 1'b1, 2'b10, 4'd6, 32'd2);

        // First wrap of the 20000-tick reset period at edge 20000
        skip_to(19999);
        rd_chk("pend_e19999", 1'b0, 1'b1, 2'b10, 4'd9, 32'h4E1F_0001);
        chk("ja_pre_wrap", 32'(ja1), 32'd0);
        tick();
        rd_chk("pend_after", 1'b0, 1'b1, 2'b10, 4'd9, 32'd0);
        rd_chk("wraps_one", 1'b0, 1'b1, 2'b10, 4'd8, 32'd1);
        cap(0, 10);
        chk("duty3_p1", 32'(pat), 32'b00_0000_0111);
        cap(0, 10);
        chk("duty3_p2", 32'(pat), 32'b00_0000_0111);

        // duty0=7 written on the wrap edge 20030
        cap(0, 9);
        wr(1'b0, 4'd0, 32'd7);
        chk("wrap_edge_ja", 32'(ja1[0]), 32'd0);
        rd_chk("pend_held", 1'b0, 1'b1, 2'b10, 4'd9, 32'd1);
        chk("duty3_p9", 32'(pat), 32'b0_0000_0111);
        cap(0, 10);
        chk("duty_still3", 32'(pat), 32'b00_0000_0111);
        rd_chk("pend_clear", 1'b0, 1'b1, 2'b10, 4'd9, 32'd0);
        cap(0, 10);
        chk("duty7", 32'(pat), 32'b00_0111_1111);

        // duty1 >= period is constantly high; enable has one-cycle latency
        wr(1'b0, 4'd1, 32'd12);
        wr(1'b0, 4'd7, 32'd2);
        skip_to(20060);
        cap(1, 10);
        chk("duty_ge_period", 32'(pat), 32'h3FF);
        chk("ch0_disabled", 32'(ja1), 32'b00_0010);
        wr(1'b0, 4'd1, 32'd0);
        wr(1'b0, 4'd7, 32'd0);
        chk("en_off_old", 32'(ja1), 32'b00_0010);
        tick();
        chk("en_off_new", 32'(ja1), 32'd0);
        wr(1'b0, 4'd7, 32'd2);
        chk("en_on_old", 32'(ja1), 32'd0);
        tick();
        chk("en_on_new", 32'(ja1), 32'b00_0010);
        skip_to(20080);
        cap(1, 10);
        chk("duty_zero", 32'(pat), 32'd0);

        // period=0 halts the timebase after wrap 20100
        wr(1'b0, 4'd6, 32'd0);
        wr(1'b0, 4'd7, 32'd4);
        skip_to(20103);
        rd_chk("halt_status", 1'b0, 1'b1, 2'b10, 4'd9, 32'd0);
        chk("halt_ja", 32'(ja1), 32'd0);
        wr(1'b0, 4'd2, 32'd2);
        wr(1'b0, 4'd6, 32'd4);
        tick();
        chk("restart_ja", 32'(ja1), 32'd0);
        rd_chk("restart_status", 1'b0, 1'b1, 2'b10, 4'd9, 32'd1);
        cap(2, 8);
        chk("pat_1100", 32'(pat), 32'b0011_0011);

        // period=1 wraps every edge: clear at a wrap edge, then roll the counter over
        wr(1'b0, 4'd6, 32'd1);
        skip_to(20118);
        wr(1'b0, 4'd8, 32'd0);
        rd_chk("clr_at_wrap", 1'b0, 1'b1, 2'b10, 4'd8, 32'd0);
        skip_to(20119 + 65535);
        rd_chk("wraps_ffff", 1'b0, 1'b1, 2'b10, 4'd8, 32'h0000_FFFF);
        tick();
        rd_chk("wraps_roll", 1'b0, 1'b1, 2'b10, 4'd8, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
